mux_key: RTL and testbench
==========================

# mux_key

Parameterized key→value lookup multiplexer with a registered output. A packed table of NR_KEY (key, data) pairs is compared against the input key. The matching entry's data is registered to the output, or DEFAULT_OUT when no entry matches. It is the shared selection primitive of the CPU datapath, used for example for memory write-mask generation, byte/half/word lane selection and load-width selection.

## Interface
Parameters:
- NR_KEY, default 2: number of table entries, ≥1.
- KEY_LEN, default 1: key width in bits, ≥1.
- DATA_LEN, default 1: data width in bits, ≥1.
- DEFAULT_OUT, default 0 (DATA_LEN bits): value driven on a miss and at reset.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous active-high reset.
- key, input, KEY_LEN: lookup key.
- lut, input, NR_KEY*(KEY_LEN+DATA_LEN): packed table.
- out, output, DATA_LEN: registered selected data.
- hit, output, 1: registered flag, set when some entry matched.
- dup_err, output, 1: registered flag, set when two or more entries matched. Present only with MUX_KEY_DUP_CHECK_EN.

## Operation
Table packing:
- Pair width P = KEY_LEN+DATA_LEN.
- Entry i occupies lut[P*(i+1)-1 : P*i].
- Entry 0 is the least-significant pair, i.e. the last pair written in a `{k,d,…}` concatenation.
- Within an entry, the key is in the upper KEY_LEN bits and the data in the lower DATA_LEN bits.

Match and selection:
- Entry i matches when its key field equals key in all bits; the comparison is exact, with no don't-care bits.
- Priority: the lowest-index matching entry supplies the data.
- Miss: the next out is DEFAULT_OUT and the next hit is 0.
- The combinational selection is fully parallel: NR_KEY comparators, a priority encoder and a data mux. There are no latches.

Parameter checks:
- NR_KEY=1 is legal: the block degenerates to a single compare.
- Parameter violations (NR_KEY<1, KEY_LEN<1 or DATA_LEN<1) are flagged by an elaboration-time $error.

## Timing
- Reset: on a rising edge with rst=1, out←DEFAULT_OUT, hit←0 and dup_err←0. rst has priority over any lookup.
- Latency: exactly 1 cycle. key and lut sampled at edge n determine out, hit and dup_err, which are valid after edge n and held until edge n+1.
- Throughput: one lookup per cycle; no handshake and no stall.
- Changes to key or lut between edges have no effect until the next edge.
- Reset in mid-stream: the lookup sampled at the reset edge is discarded. The first post-reset result appears one cycle after rst deasserts.

## Configuration
- MUX_KEY_DUP_CHECK_EN defined:
  - the dup_err port exists;
  - it is registered high in the cycle after any edge at which ≥2 entries matched key;
  - out still follows lowest-index priority.
- MUX_KEY_DUP_CHECK_EN undefined:
  - no dup_err port and no population-count logic;
  - all other behaviour is identical.

## Test plan
Common setup for scenarios 1–4: NR_KEY=4, KEY_LEN=2, DATA_LEN=8, DEFAULT_OUT=8'h00, lut={2'd0,8'h01, 2'd1,8'h03, 2'd2,8'h0f, 2'd3,8'hff}.

1. Reset: rst=1 for 2 cycles with key=3 → out=8'h00 and hit=0 throughout and in the first cycle after release. On the next edge out=8'hff and hit=1.
2. Full sweep: key 0,1,2,3 on consecutive cycles → out 8'h01, 8'h03, 8'h0f, 8'hff, each one cycle after its key, with hit=1.
3. Miss: NR_KEY=2, KEY_LEN=3, DATA_LEN=8, DEFAULT_OUT=8'hAA, lut={3'b000,8'h11, 3'b100,8'h22}, key=3'b010 → out=8'hAA, hit=0. Then key=3'b100 → out=8'h22.
4. Duplicates: lut={2'd1,8'h55, 2'd1,8'h66, 2'd0,8'h01, 2'd3,8'hff}, key=1 → out=8'h66 (entry 2 beats entry 3). With the macro, dup_err=1; key=0 next cycle → dup_err=0.
5. Mid-stream reset: keys 0,1,2 streaming with rst asserted on the edge that samples key=1 → outputs seen are 8'h01, then DEFAULT 8'h00, then 8'h0f.
6. Wide config: NR_KEY=8, KEY_LEN=3, DATA_LEN=64, data i = 64'h1 << (8*i). Random keys for 1000 cycles checked against a reference model, including back-to-back lut changes with a fixed key.

Source files
------------

// File: rtl/mux_key.sv
// mux_key: key -> value lookup multiplexer with a registered output.
// A packed table of NR_KEY (key, data) pairs is compared against key; the
// lowest-index matching entry's data is registered to out, DEFAULT_OUT on a
// miss. One lookup per cycle, 1-cycle latency, no handshake, no stall.
// Optional build macro MUX_KEY_DUP_CHECK_EN adds the dup_err output, which
// flags a lookup where two or more entries matched.
module mux_key #(
  parameter int                  NR_KEY      = 2,
  parameter int                  KEY_LEN     = 1,
  parameter int                  DATA_LEN    = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT_OUT = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                   out,
  output logic                                  hit
`ifdef MUX_KEY_DUP_CHECK_EN
  ,
  output logic                                  dup_err
`endif
);

  localparam int P = KEY_LEN + DATA_LEN;

  // Reject degenerate geometries at elaboration time.
  if (NR_KEY < 1 || KEY_LEN < 1 || DATA_LEN < 1) begin : g_bad_param
    $error("mux_key: NR_KEY, KEY_LEN and DATA_LEN must all be >= 1");
  end

  logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
  logic [DATA_LEN-1:0] entry_data [NR_KEY];
  logic [NR_KEY-1:0]   match;

  // Unpack each pair (key in the upper bits, data in the lower bits) and
  // compare its key exactly against the lookup key.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
    assign entry_key[i]  = lut[P*i+DATA_LEN +: KEY_LEN];
    assign entry_data[i] = lut[P*i +: DATA_LEN];
    assign match[i]      = (entry_key[i] == key);
  end

  logic [DATA_LEN-1:0] sel_data;
  logic                sel_hit;

  // Priority select: the first (lowest-index) match supplies the data.
  always_comb begin
    sel_data = DEFAULT_OUT;
    sel_hit  = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!sel_hit && match[i]) begin
        sel_hit  = 1'b1;
        sel_data = entry_data[i];
      end
    end
  end

  // Register the selected data and hit flag; reset wins over any lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= DEFAULT_OUT;
      hit <= 1'b0;
    end else begin
      out <= sel_data;
      hit <= sel_hit;
    end
  end

`ifdef MUX_KEY_DUP_CHECK_EN
  logic sel_dup;

  // Two-or-more detector: a match after an earlier match is a duplicate.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    sel_dup = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        if (seen) sel_dup = 1'b1;
        seen = 1'b1;
      end
    end
  end

  // Register the duplicate flag alongside out/hit.
  always_ff @(posedge clk) begin
    if (rst) dup_err <= 1'b0;
    else     dup_err <= sel_dup;
  end
`endif

endmodule

// File: tb/tb_mux_key.sv
// tb_mux_key: directed bench for mux_key. Three instances cover the 4x2x8
// table, the 2x3x8 miss table with a non-zero default, and the 8x3x64 wide
// table under random keys and random table rewrites.
module tb_mux_key;

  localparam logic [63:0] DEF_C = 64'hdead_beef_0000_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 entries, 2-bit key, 8-bit data ----------------
  logic [1:0]  key_a;
  logic [39:0] lut_a;
  logic [7:0]  out_a;
  logic        hit_a;
`ifdef MUX_KEY_DUP_CHECK_EN
  logic        dup_a;
`endif

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .DEFAULT_OUT(8'h00)) u_a (
    .clk(clk), .rst(rst), .key(key_a), .lut(lut_a), .out(out_a), .hit(hit_a)
`ifdef MUX_KEY_DUP_CHECK_EN
    , .dup_err(dup_a)
`endif
  );

  // ---------------- DUT B: 2 entries, 3-bit key, default AA ----------------
  logic [2:0]  key_b;
  logic [21:0] lut_b;
  logic [7:0]  out_b;
  logic        hit_b;
`ifdef MUX_KEY_DUP_CHECK_EN
  logic        dup_b;
`endif

  mux_key #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(8), .DEFAULT_OUT(8'hAA)) u_b (
    .clk(clk), .rst(rst), .key(key_b), .lut(lut_b), .out(out_b), .hit(hit_b)
`ifdef MUX_KEY_DUP_CHECK_EN
    , .dup_err(dup_b)
`endif
  );

  // ---------------- DUT C: 8 entries, 3-bit key, 64-bit data ----------------
  logic [2:0]     key_c;
  logic [8*67-1:0] lut_c;
  logic [63:0]    out_c;
  logic           hit_c;
`ifdef MUX_KEY_DUP_CHECK_EN
  logic           dup_c;
`endif

  mux_key #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(64), .DEFAULT_OUT(DEF_C)) u_c (
    .clk(clk), .rst(rst), .key(key_c), .lut(lut_c), .out(out_c), .hit(hit_c)
`ifdef MUX_KEY_DUP_CHECK_EN
    , .dup_err(dup_c)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic        exp_hit_q[$];
  logic        exp_dup_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then settle 1 time unit so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference lookup for DUT C: lowest-index match wins, count duplicates.
  task automatic model_c(input logic [8*67-1:0] l, input logic [2:0] k,
                         output logic [63:0] o, output logic h, output logic d);
    o = DEF_C;
    h = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (l[67*i+64 +: 3] == k) begin
        if (h) d = 1'b1;
        else begin
          o = l[67*i +: 64];
          h = 1'b1;
        end
      end
    end
  endtask

  task automatic build_lut_c(input logic [23:0] keys);
    for (int i = 0; i < 8; i++) begin
      lut_c[67*i +: 67] = {keys[3*i +: 3], 64'h1 << (8*i)};
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [39:0] base_lut;
    logic [39:0] dup_lut;
    logic [63:0] m_o;
    logic        m_h;
    logic        m_d;
    logic [23:0] rkeys;

    base_lut = {2'd0, 8'h01, 2'd1, 8'h03, 2'd2, 8'h0f, 2'd3, 8'hff};
    dup_lut  = {2'd1, 8'h55, 2'd1, 8'h66, 2'd0, 8'h01, 2'd3, 8'hff};
    lut_a = base_lut;
    key_a = 2'd3;
    lut_b = {3'b000, 8'h11, 3'b100, 8'h22};
    key_b = 3'b010;
    build_lut_c({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    key_c = 3'd0;

    // 1. reset held two cycles with key=3, then release
    rst = 1'b1;
    tick();
    chk("rst1_out", 64'(out_a), 64'h00);
    chk("rst1_hit", 64'(hit_a), 64'h0);
    tick();
    chk("rst2_out", 64'(out_a), 64'h00);
    chk("rst2_hit", 64'(hit_a), 64'h0);
    chk("rst_b_out", 64'(out_b), 64'hAA);
    chk("rst_c_out", out_c, DEF_C);
`ifdef MUX_KEY_DUP_CHECK_EN
    chk("rst_dup", 64'(dup_a), 64'h0);
`endif
    rst = 1'b0;
    #3;
    chk("rel_out", 64'(out_a), 64'h00);
    chk("rel_hit", 64'(hit_a), 64'h0);
    tick();
    chk("post_rst_out", 64'(out_a), 64'hff);
    chk("post_rst_hit", 64'(hit_a), 64'h1);

    // 2. full sweep of keys 0..3
    key_a = 2'd0; tick(); chk("sweep0", 64'(out_a), 64'h01); chk("sweep0_hit", 64'(hit_a), 64'h1);
    key_a = 2'd1; tick(); chk("sweep1", 64'(out_a), 64'h03); chk("sweep1_hit", 64'(hit_a), 64'h1);
    key_a = 2'd2; tick(); chk("sweep2", 64'(out_a), 64'h0f); chk("sweep2_hit", 64'(hit_a), 64'h1);
    key_a = 2'd3; tick(); chk("sweep3", 64'(out_a), 64'hff); chk("sweep3_hit", 64'(hit_a), 64'h1);

    // 3. miss returns DEFAULT_OUT on DUT B, then hits
    key_b = 3'b010; tick();
    chk("miss_out", 64'(out_b), 64'hAA);
    chk("miss_hit", 64'(hit_b), 64'h0);
    key_b = 3'b100; tick();
    chk("hit100_out", 64'(out_b), 64'h22);
    chk("hit100_hit", 64'(hit_b), 64'h1);
    key_b = 3'b000; tick();
    chk("hit000_out", 64'(out_b), 64'h11);

    // 4. duplicate keys: entry 2 beats entry 3
    lut_a = dup_lut;
    key_a = 2'd1; tick();
    chk("dup_out", 64'(out_a), 64'h66);
    chk("dup_hit", 64'(hit_a), 64'h1);
`ifdef MUX_KEY_DUP_CHECK_EN
    chk("dup_flag", 64'(dup_a), 64'h1);
`endif
    key_a = 2'd0; tick();
    chk("dup_next_out", 64'(out_a), 64'h01);
`ifdef MUX_KEY_DUP_CHECK_EN
    chk("dup_clear", 64'(dup_a), 64'h0);
`endif
    key_a = 2'd2; tick();
    chk("dup_miss_out", 64'(out_a), 64'h00);
    chk("dup_miss_hit", 64'(hit_a), 64'h0);

    // 5. mid-stream reset discards the lookup sampled at the reset edge
    lut_a = base_lut;
    key_a = 2'd0; tick();
    chk("mid0", 64'(out_a), 64'h01);
    key_a = 2'd1; rst = 1'b1; tick();
    chk("mid_rst", 64'(out_a), 64'h00);
    chk("mid_rst_hit", 64'(hit_a), 64'h0);
    key_a = 2'd2; rst = 1'b0; tick();
    chk("mid2", 64'(out_a), 64'h0f);

    // 6a. wide table, random keys against identity table
    for (int n = 0; n < 500; n++) begin
      key_c = 3'($urandom_range(0, 7));
      model_c(lut_c, key_c, m_o, m_h, m_d);
      exp_q.push_back(m_o);
      exp_hit_q.push_back(m_h);
      exp_dup_q.push_back(m_d);
      tick();
      chk("wide_out", out_c, exp_q.pop_front());
      chk("wide_hit", 64'(hit_c), 64'(exp_hit_q.pop_front()));
`ifdef MUX_KEY_DUP_CHECK_EN
      chk("wide_dup", 64'(dup_c), 64'(exp_dup_q.pop_front()));
`else
      void'(exp_dup_q.pop_front());
`endif
    end

    // 6b. fixed key, table keys rewritten every cycle (misses and duplicates)
    key_c = 3'd5;
    for (int n = 0; n < 500; n++) begin
      rkeys = 24'($urandom);
      build_lut_c(rkeys);
      model_c(lut_c, key_c, m_o, m_h, m_d);
      exp_q.push_back(m_o);
      exp_hit_q.push_back(m_h);
      exp_dup_q.push_back(m_d);
      tick();
      chk("lutchg_out", out_c, exp_q.pop_front());
      chk("lutchg_hit", 64'(hit_c), 64'(exp_hit_q.pop_front()));
`ifdef MUX_KEY_DUP_CHECK_EN
      chk("lutchg_dup", 64'(dup_c), 64'(exp_dup_q.pop_front()));
`else
      void'(exp_dup_q.pop_front());
`endif
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
